// File: rtl/adder_pkg.sv
// Shared constants and reference arithmetic for the grouped carry-lookahead adder.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: DEFAULT_WIDTH / DEFAULT_GROUP localparams and ref_add(), the exact
// (WIDTH+1)-bit sum used by benches and assertions as the golden result.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_GROUP = 4;

  // Exact a+b+cin in DEFAULT_WIDTH+1 bits; bit DEFAULT_WIDTH is the carry-out.
  function automatic logic [DEFAULT_WIDTH:0] ref_add(
    input logic [DEFAULT_WIDTH-1:0] a,
    input logic [DEFAULT_WIDTH-1:0] b,
    input logic                     cin
  );
    logic [DEFAULT_WIDTH:0] ax;
    logic [DEFAULT_WIDTH:0] bx;
    logic [DEFAULT_WIDTH:0] cx;
    ax = {1'b0, a};
    bx = {1'b0, b};
    cx = {{DEFAULT_WIDTH{1'b0}}, cin};
    return ax + bx + cx;
  endfunction

endpackage

// File: rtl/cla_group.sv
// One carry-lookahead group: GROUP-bit sum plus group generate/propagate.
// Latency: purely combinational.
// Backpressure: none (no handshake).
// Ports: a, b (GROUP-bit operands), ci (carry into bit 0 of the group),
//        s (GROUP-bit sum), gg (group generate), gp (group propagate).
module cla_group
  import adder_pkg::*;
#(
  parameter int GROUP = DEFAULT_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic             gg,
  output logic             gp
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP-1:0] c;   // carry into each bit of the group
  logic             pp;
  logic             t;

  assign g = a & b;
  assign p = a ^ b;

  // Every internal carry is a flat sum of products over g/p/ci rather than a
  // ripple, so each one is two logic levels deep regardless of its position:
  //   c[i] = ci&p[0..i-1] | OR_j ( g[j] & p[j+1..i-1] )
  always_comb begin
    c  = '0;
    pp = 1'b0;
    t  = 1'b0;
    c[0] = ci;
    for (int i = 1; i < GROUP; i++) begin
      pp = ci;
      for (int j = 0; j < i; j++) pp = pp & p[j];
      c[i] = pp;
      for (int j = 0; j < i; j++) begin
        t = g[j];
        for (int k = j + 1; k < i; k++) t = t & p[k];
        c[i] = c[i] | t;
      end
    end
  end

  // Group generate is the carry out of the group assuming ci=0.
  always_comb begin
    gg = 1'b0;
    for (int j = 0; j < GROUP; j++) begin
      if (j == 0) gg = g[j];
      else        gg = g[j] | (p[j] & gg);
    end
  end

  assign gp = &p;
  assign s  = p ^ c;

endmodule

// File: rtl/full_adder32.sv
// Registered WIDTH-bit adder with carry-in/out built from chained lookahead groups.
// Latency: 1 cycle, operands at edge N give {cout,sum} after edge N; 1 op/clock.
// Backpressure: none, a new operation is accepted every cycle.
// Ports: clk, rst_n (async active-low), a, b (unsigned operands), cin,
//        sum (registered low WIDTH bits of a+b+cin), cout (registered bit WIDTH).
module full_adder32
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int GROUP = DEFAULT_GROUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NG = WIDTH / GROUP;

  logic [NG:0]      gc;     // carry into each group; gc[NG] is the final carry
  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;
  logic [WIDTH-1:0] sum_c;

  assign gc[0] = cin;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group #(.GROUP(GROUP)) u_grp (
      .a  (a[k*GROUP +: GROUP]),
      .b  (b[k*GROUP +: GROUP]),
      .ci (gc[k]),
      .s  (sum_c[k*GROUP +: GROUP]),
      .gg (gg[k]),
      .gp (gp[k])
    );
    // Group-level chain: only NG stages deep, each a single AND-OR.
    assign gc[k+1] = gg[k] | (gp[k] & gc[k]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= sum_c;
      cout <= gc[NG];
    end
  end

endmodule

// File: tb/tb_full_adder32.sv
// Directed and random checks of full_adder32 against hand values and ref_add.
// Latency: expects results one rising edge after operands are applied.
// Backpressure: n/a.
module tb_full_adder32;
  import adder_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [31:0] sum;
  logic        cout;

  int total;
  int bad;

  full_adder32 #(.WIDTH(32), .GROUP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got cout=%0b sum=%08h, want cout=%0b sum=%08h",
               tag, obs[32], obs[31:0], exp[32], exp[31:0]);
    end
  endtask

  // Call at a falling edge: drive operands, then check at the next falling edge.
  task automatic step(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                      input logic tc, input logic [32:0] exp);
    a   = ta;
    b   = tb_;
    cin = tc;
    @(negedge clk);
    chk(tag, {cout, sum}, exp);
  endtask

  logic [31:0] ra;
  logic [31:0] rb;
  logic        rc;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    a     = 32'h0;
    b     = 32'h0;
    cin   = 1'b0;

    #2;
    chk("reset_state", {cout, sum}, 33'h0);

    // Load a nonzero result so the asynchronous clear is observable.
    @(negedge clk);
    rst_n = 1'b1;
    step("pre_reset_load", 32'h12345678, 32'h00000001, 1'b0, {1'b0, 32'h12345679});

    // Assert reset mid-cycle while clk is high; clear must not wait for an edge.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_async", {cout, sum}, 33'h0);
    @(negedge clk);
    @(negedge clk);
    chk("reset_hold", {cout, sum}, 33'h0);
    rst_n = 1'b1;
    step("post_reset_zero", 32'h0, 32'h0, 1'b0, 33'h0);

    step("wrap_b1",      32'hFFFFFFFF, 32'h00000001, 1'b0, {1'b1, 32'h00000000});
    step("wrap_cin",     32'hFFFFFFFF, 32'h00000000, 1'b1, {1'b1, 32'h00000000});
    step("max_cin1",     32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, {1'b1, 32'hFFFFFFFF});
    step("max_cin0",     32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, {1'b1, 32'hFFFFFFFE});
    step("ripple_31",    32'h7FFFFFFF, 32'h00000001, 1'b0, {1'b0, 32'h80000000});
    step("ripple_16",    32'h0000FFFF, 32'h00000001, 1'b0, {1'b0, 32'h00010000});
    step("mixed",        32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, {1'b1, 32'h00000000});
    step("group_border", 32'h0000000F, 32'h00000001, 1'b0, {1'b0, 32'h00000010});

    // Back-to-back: each result must appear after one edge and be replaced
    // by the next one an edge later.
    step("b2b_0", 32'h00000001, 32'h00000002, 1'b0, {1'b0, 32'h00000003});
    step("b2b_1", 32'h0000000A, 32'h00000014, 1'b1, {1'b0, 32'h0000001F});
    step("b2b_2", 32'h80000000, 32'h80000000, 1'b0, {1'b1, 32'h00000000});
    // Hold check: with operands unchanged, result still stable just before next edge.
    #4;
    chk("b2b_hold", {cout, sum}, {1'b1, 32'h00000000});
    @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      step("random", ra, rb, rc, ref_add(ra, rb, rc));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
